// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decode plus iterative MULT/DIV engine with HI/LO; decode is combinational.
// Engine result is written WIDTH+2 cycles after accept (1 for div-by-zero); HI/LO consumers stall while busy.
module alu_muldiv_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CONF_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic              start,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [CONF_W-1:0] ALUConf,
  output logic              Sign,
  output logic [WIDTH-1:0]  hilo_out,
  output logic              md_busy,
  output logic              md_done,
  output logic              stall
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [4:0]         conf;
  logic               rfmt, md_op, hilo_op;
  logic [WIDTH-1:0]   hi, lo, dvs, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, mul_nx, div_nx, fix_nx;
  logic [WIDTH:0]     mul_sum, div_part, div_diff;
  logic [CW-1:0]      cnt;
  logic               sa, sb, op_div;

  assign rfmt    = (ALUOp[2:0] == 3'b010);
  assign md_op   = start & rfmt & (Funct[5:2] == 4'b0110);
  assign hilo_op = start & rfmt & (Funct[5:2] == 4'b0100);

  always_comb begin
    conf = 5'b00000;
    if (rfmt) begin
      case (Funct)
        6'h00:         conf = 5'b11001;
        6'h02:         conf = 5'b10000;
        6'h03:         conf = 5'b11000;
        6'h22, 6'h23:  conf = 5'b00110;
        6'h24:         conf = 5'b00010;
        6'h25:         conf = 5'b00001;
        6'h26:         conf = 5'b01101;
        6'h27:         conf = 5'b01100;
        6'h2A, 6'h2B:  conf = 5'b00111;
        6'h3F:         conf = 5'b11111;
        default:       conf = 5'b00000;
      endcase
    end else begin
      case (ALUOp[2:0])
        3'b001:  conf = 5'b00110;
        3'b100:  conf = 5'b00010;
        3'b101:  conf = 5'b00111;
        default: conf = 5'b00000;
      endcase
    end
  end

  assign ALUConf  = CONF_W'(conf);
  assign Sign     = rfmt ? ~Funct[0] : ~ALUOp[3];
  assign hilo_out = Funct[1] ? lo : hi;
  assign md_busy  = (state != IDLE);
  assign md_done  = (state == DONE);
  assign stall    = md_busy & (md_op | hilo_op);

  // Signed ops run on magnitudes; |MIN| is exact when read as unsigned.
  assign abs_a = (Sign & A[WIDTH-1]) ? -A : A;
  assign abs_b = (Sign & B[WIDTH-1]) ? -B : B;

  // Shift-add: upper half accumulates, multiplier shifts out of the low half.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: remainder in the upper half, quotient bits enter at bit 0.
  assign div_part = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, dvs};
  assign div_nx   = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_comb begin
    fix_nx = acc;
    if (op_div) begin
      if (sa)      fix_nx[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
      if (sa ^ sb) fix_nx[WIDTH-1:0]       = -acc[WIDTH-1:0];
    end else if (sa ^ sb) begin
      fix_nx = -acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (md_op) state_nx = !Funct[1] ? MUL : ((B == '0) ? DONE : DIV);
      MUL:  if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      DIV:  if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      op_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_op) begin
            cnt    <= '0;
            sa     <= Sign & A[WIDTH-1];
            sb     <= Sign & B[WIDTH-1];
            op_div <= Funct[1];
            dvs    <= abs_b;
            if (Funct[1] && (B == '0)) acc <= {A, {WIDTH{1'b1}}};
            else                       acc <= {{WIDTH{1'b0}}, abs_a};
          end else if (hilo_op && Funct[0]) begin
            if (Funct[1]) lo <= A;
            else          hi <= A;
          end
        end
        MUL: begin
          acc <= mul_nx;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_nx;
          cnt <= cnt + 1'b1;
        end
        FIX: acc <= fix_nx;
        DONE: begin
          hi <= acc[2*WIDTH-1:WIDTH];
          lo <= acc[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboarded bench for alu_muldiv_ctrl: decode table sweep, directed mult/div cases, random traffic, reset abort.
module tb_alu_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   aluop;
  logic [5:0]   funct;
  logic         start;
  logic [W-1:0] opa, opb;
  logic [4:0]   aluconf;
  logic         sign;
  logic [W-1:0] hilo_out;
  logic         md_busy, md_done, stall;

  alu_muldiv_ctrl #(.WIDTH(W), .CONF_W(5)) dut (
    .clk(clk), .reset(reset), .ALUOp(aluop), .Funct(funct), .start(start),
    .A(opa), .B(opb), .ALUConf(aluconf), .Sign(sign), .hilo_out(hilo_out),
    .md_busy(md_busy), .md_done(md_done), .stall(stall)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, cyc = 0, busy_cnt = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];
  int acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic failn(input string nm);
    total++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [4:0] ref_conf(input logic [3:0] op, input logic [5:0] f);
    if (op[2:0] == 3'b010) begin
      case (f)
        6'h00: return 5'b11001;
        6'h02: return 5'b10000;
        6'h03: return 5'b11000;
        6'h22, 6'h23: return 5'b00110;
        6'h24: return 5'b00010;
        6'h25: return 5'b00001;
        6'h26: return 5'b01101;
        6'h27: return 5'b01100;
        6'h2A, 6'h2B: return 5'b00111;
        6'h3F: return 5'b11111;
        default: return 5'b00000;
      endcase
    end
    case (op[2:0])
      3'b001: return 5'b00110;
      3'b100: return 5'b00010;
      3'b101: return 5'b00111;
      default: return 5'b00000;
    endcase
  endfunction

  // Reference arithmetic on 64-bit integers.
  task automatic model_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint sq, sr;
    case (f)
      6'h18: p = 64'(longint'(int'(a)) * longint'(int'(b)));
      6'h19: p = 64'(a) * 64'(b);
      6'h1A: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = longint'(int'(a)) / longint'(int'(b));
          sr = longint'(int'(a)) % longint'(int'(b));
          p = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    m_hi = p[63:32];
    m_lo = p[31:0];
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic st0);
    int n;
    if (f inside {[6'h18:6'h1B]}) begin
      lat_q.push_back((f[1] && b == 0) ? 1 : W + 2);
      model_md(f, a, b);
    end else if (f == 6'h11) m_hi = a;
    else if (f == 6'h13) m_lo = a;
    else if (f == 6'h10) exp_q.push_back(m_hi);
    else if (f == 6'h12) exp_q.push_back(m_lo);
    aluop = 4'b0010; funct = f; opa = a; opb = b; start = 1'b1;
    n = 0;
    @(negedge clk);
    st0 = stall;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n == 100) chk("accept_timeout", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic iss(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic d;
    issue(f, a, b, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: pairs each accepted instruction with the DUT response.
  always @(negedge clk) begin
    if (!reset) busy_cnt = 0;
    else begin
      if (md_busy) busy_cnt++;
      if (start && aluop[2:0] == 3'b010 && !stall) begin
        if (funct inside {[6'h18:6'h1B]}) acc_q.push_back(cyc);
        if (funct == 6'h10 || funct == 6'h12) begin
          if (exp_q.size() > 0) chk(funct == 6'h10 ? "mfhi_value" : "mflo_value", 64'(hilo_out), 64'(exp_q.pop_front()));
          else failn("mf_read_without_expectation");
        end
      end
      if (md_done) begin
        if (lat_q.size() > 0 && acc_q.size() > 0) begin
          int l, a0;
          l = lat_q.pop_front();
          a0 = acc_q.pop_front();
          chk("md_latency", 64'(cyc - a0), 64'(l));
          chk("md_busy_cycles", 64'(busy_cnt), 64'(l));
        end else failn("unexpected_md_done");
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    reset = 1'b0; start = 1'b0; aluop = 4'b0010; funct = 6'h10; opa = '0; opb = '0;
    #1;
    chk("rst_busy", {63'd0, md_busy}, 64'd0);
    chk("rst_done", {63'd0, md_done}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_hi", 64'(hilo_out), 64'd0);
    funct = 6'h12; #1;
    chk("rst_lo", 64'(hilo_out), 64'd0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Decode table sweep
    for (int f = 0; f < 64; f++) begin
      for (int k = 0; k < 2; k++) begin
        aluop = k ? 4'b1010 : 4'b0010; funct = 6'(f); #1;
        chk($sformatf("decode_op%h_f%h", aluop, funct), {59'd0, aluconf, sign},
            {59'd0, ref_conf(aluop, funct), ~funct[0]});
      end
    end
    for (int o = 0; o < 16; o++) begin
      aluop = 4'(o); funct = 6'($urandom); #1;
      chk($sformatf("decode_op%h_f%h", aluop, funct), {59'd0, aluconf, sign},
          {59'd0, ref_conf(aluop, funct), (aluop[2:0] == 3'b010) ? ~funct[0] : ~aluop[3]});
    end
    aluop = 4'b0010; idle(1);

    // Directed arithmetic
    iss(6'h19, 32'd3, 32'd5);           iss(6'h12, '0, '0); iss(6'h10, '0, '0);
    iss(6'h18, -32'sd2, 32'd3);         iss(6'h10, '0, '0); iss(6'h12, '0, '0);
    iss(6'h19, -32'sd2, 32'd3);         iss(6'h10, '0, '0); iss(6'h12, '0, '0);
    iss(6'h1A, -32'sd7, 32'd2);         iss(6'h12, '0, '0); iss(6'h10, '0, '0);
    iss(6'h1B, 32'd7, 32'd0);           iss(6'h12, '0, '0); iss(6'h10, '0, '0);
    iss(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF); iss(6'h12, '0, '0); iss(6'h10, '0, '0);
    iss(6'h11, 32'hDEAD_BEEF, '0); iss(6'h13, 32'h0123_4567, '0);
    iss(6'h10, '0, '0); iss(6'h12, '0, '0);

    // HI/LO consumer behind a busy engine stalls; unrelated ALU op does not
    iss(6'h18, 32'd1234567, -32'sd89);
    aluop = 4'b0010; funct = 6'h20; start = 1'b1;
    @(negedge clk);
    chk("alu_op_no_stall", {63'd0, stall}, 64'd0);
    chk("busy_during_mult", {63'd0, md_busy}, 64'd1);
    @(posedge clk); #1; start = 1'b0;
    idle(3);
    issue(6'h10, '0, '0, st);
    chk("mfhi_stalled_when_busy", {63'd0, st}, 64'd1);
    chk("stall_clear_after_done", {63'd0, stall}, 64'd0);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4) iss(6'h18 + 6'(k), rnd_op(), rnd_op());
      else if (k == 4) iss(6'h11, rnd_op(), '0);
      else if (k == 5) iss(6'h13, rnd_op(), '0);
      else if (k < 8) iss(6'h10, '0, '0);
      else if (k == 8) iss(6'h12, '0, '0);
      else idle($urandom_range(1, 5));
    end
    iss(6'h10, '0, '0); iss(6'h12, '0, '0);

    // Reset during a divide
    iss(6'h1B, 32'd1000, 32'd7);
    idle(9);
    #3 reset = 1'b0;
    lat_q.delete(); acc_q.delete(); exp_q.delete();
    m_hi = '0; m_lo = '0;
    #1;
    chk("abort_busy", {63'd0, md_busy}, 64'd0);
    chk("abort_done", {63'd0, md_done}, 64'd0);
    funct = 6'h10; #1;
    chk("abort_hi", 64'(hilo_out), 64'd0);
    funct = 6'h12; #1;
    chk("abort_lo", 64'(hilo_out), 64'd0);
    #7 reset = 1'b1;
    idle(45);
    iss(6'h10, '0, '0); iss(6'h12, '0, '0);

    idle(5);
    chk("queues_drained", 64'(exp_q.size() + lat_q.size() + acc_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
